// File: rtl/alu_pkg.sv
// alu_pkg: select codes and saturation limits shared by the ALU datapath
package alu_pkg;
  localparam logic [2:0] SRC1_ACCUM  = 3'd0;
  localparam logic [2:0] SRC1_ITERM  = 3'd1;
  localparam logic [2:0] SRC1_ERR    = 3'd2;
  localparam logic [2:0] SRC1_ERRSH  = 3'd3;
  localparam logic [2:0] SRC1_FWD    = 3'd4;
  localparam logic [2:0] SRC0_A2D    = 3'd0;
  localparam logic [2:0] SRC0_INTGRL = 3'd1;
  localparam logic [2:0] SRC0_ICOMP  = 3'd2;
  localparam logic [2:0] SRC0_PCOMP  = 3'd3;
  localparam logic [2:0] SRC0_PTERM  = 3'd4;
  localparam logic [15:0] SAT12_POS = 16'h07FF;
  localparam logic [15:0] SAT12_NEG = 16'hF800;
  localparam logic [15:0] SAT14_POS = 16'h3FFF;
  localparam logic [15:0] SAT14_NEG = 16'hC000;
endpackage

// File: rtl/alu_sat_mult.sv
// alu_sat_mult: 15x15 signed fixed-point multiply saturated to 14-bit signed
module alu_sat_mult
  import alu_pkg::*;
(
  input  logic [14:0] a,
  input  logic [14:0] b,
  output logic [15:0] p
);
  logic signed [29:0] prod;
  assign prod = $signed(a) * $signed(b);
  always_comb
    p = (!prod[29] && |prod[28:26]) ? SAT14_POS :
        (prod[29] && !(&prod[28:26])) ? SAT14_NEG : prod[27:12];
endmodule

// File: rtl/alu.sv
// alu: operand muxes, src0 scaler, add/sub with 12-bit saturation or multiply, registered dst
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] accum,
  input  logic [15:0] pcomp,
  input  logic [11:0] icomp,
  input  logic [13:0] pterm,
  input  logic [11:0] iterm,
  input  logic [11:0] fwd,
  input  logic [11:0] a2d_res,
  input  logic [11:0] error,
  input  logic [11:0] intgrl,
  input  logic [2:0]  src0sel,
  input  logic [2:0]  src1sel,
  input  logic        multiply,
  input  logic        sub,
  input  logic        mult2,
  input  logic        mult4,
  input  logic        saturate,
  output logic [15:0] dst
);
  logic [15:0] src1, src0, scaled, sum, add_res, mult_res, dst_d, dst_q;
  always_comb begin
    src1 = src1sel == SRC1_ACCUM ? accum :
           src1sel == SRC1_ITERM ? {4'b0, iterm} :
           src1sel == SRC1_ERR   ? {{4{error[11]}}, error} :
           src1sel == SRC1_ERRSH ? {{8{error[11]}}, error[11:4]} :
           src1sel == SRC1_FWD   ? {4'b0, fwd} : 16'h0000;
    src0 = src0sel == SRC0_A2D    ? {4'b0, a2d_res} :
           src0sel == SRC0_INTGRL ? {{4{intgrl[11]}}, intgrl} :
           src0sel == SRC0_ICOMP  ? {{4{icomp[11]}}, icomp} :
           src0sel == SRC0_PCOMP  ? pcomp :
           src0sel == SRC0_PTERM  ? {2'b0, pterm} : 16'h0000;
    scaled = mult4 ? {src0[13:0], 2'b00} : mult2 ? {src0[14:0], 1'b0} : src0;
    sum = src1 + (sub ? ~scaled + 16'd1 : scaled);
    add_res = !saturate ? sum :
              (!sum[15] && |sum[14:11]) ? SAT12_POS :
              (sum[15] && !(&sum[14:11])) ? SAT12_NEG : sum;
    dst_d = multiply ? mult_res : add_res;
  end
  alu_sat_mult u_mult (.a(src1[14:0]), .b(src0[14:0]), .p(mult_res));
  always_ff @(posedge clk) dst_q <= rst ? 16'h0000 : dst_d;
  assign dst = dst_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: vector table, hand sequences and random stimulus against an arithmetic reference model
module tb_alu;
  typedef struct packed {
    logic [15:0] accum, pcomp;
    logic [11:0] icomp;
    logic [13:0] pterm;
    logic [11:0] iterm, fwd, a2d_res, error, intgrl;
    logic [2:0]  s0, s1;
    logic        mul, sub, m2, m4, sat;
    logic [15:0] exp;
  } vec_t;

  logic clk = 0, rst = 1;
  logic [15:0] accum, pcomp;
  logic [11:0] icomp, iterm, fwd, a2d_res, error, intgrl;
  logic [13:0] pterm;
  logic [2:0]  src0sel, src1sel;
  logic        multiply, sub, mult2, mult4, saturate;
  logic [15:0] dst;
  int total = 0, bad = 0;
  vec_t tbl[$];

  alu dut (.clk(clk), .rst(rst), .accum(accum), .pcomp(pcomp), .icomp(icomp), .pterm(pterm),
           .iterm(iterm), .fwd(fwd), .a2d_res(a2d_res), .error(error), .intgrl(intgrl),
           .src0sel(src0sel), .src1sel(src1sel), .multiply(multiply), .sub(sub),
           .mult2(mult2), .mult4(mult4), .saturate(saturate), .dst(dst));

  always #5 clk = ~clk;

  function automatic int wrap15(int x);
    int w = ((x % 32768) + 32768) % 32768;
    return w >= 16384 ? w - 32768 : w;
  endfunction

  function automatic logic [15:0] model(vec_t v);
    int a, b, r, sv;
    case (v.s1)
      3'd0: a = int'($signed(v.accum));
      3'd1: a = int'(v.iterm);
      3'd2: a = int'($signed(v.error));
      3'd3: a = int'($signed(v.error)) >>> 4;
      3'd4: a = int'(v.fwd);
      default: a = 0;
    endcase
    case (v.s0)
      3'd0: b = int'(v.a2d_res);
      3'd1: b = int'($signed(v.intgrl));
      3'd2: b = int'($signed(v.icomp));
      3'd3: b = int'($signed(v.pcomp));
      3'd4: b = int'(v.pterm);
      default: b = 0;
    endcase
    if (v.mul) begin
      r = wrap15(a) * wrap15(b);
      if (r >= (1 << 26)) return 16'h3FFF;
      if (r < -(1 << 26)) return 16'hC000;
      return 16'((r >>> 12) & 32'hFFFF);
    end
    r = v.sub ? a - b * (v.m4 ? 4 : v.m2 ? 2 : 1) : a + b * (v.m4 ? 4 : v.m2 ? 2 : 1);
    r = r & 32'hFFFF;
    sv = r >= 32768 ? r - 65536 : r;
    if (v.sat && sv > 2047) return 16'h07FF;
    if (v.sat && sv < -2048) return 16'hF800;
    return 16'(r);
  endfunction

  task automatic drive(vec_t v);
    accum = v.accum; pcomp = v.pcomp; icomp = v.icomp; pterm = v.pterm; iterm = v.iterm;
    fwd = v.fwd; a2d_res = v.a2d_res; error = v.error; intgrl = v.intgrl;
    src0sel = v.s0; src1sel = v.s1; multiply = v.mul; sub = v.sub;
    mult2 = v.m2; mult4 = v.m4; saturate = v.sat;
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: dst=%h expected=%h", name, act, want);
    end
  endtask

  task automatic apply(string name, vec_t v);
    drive(v);
    @(posedge clk); #1;
    chk(name, dst, v.exp);
  endtask

  function automatic vec_t rnd();
    vec_t v;
    v.accum = 16'($urandom); v.pcomp = 16'($urandom); v.icomp = 12'($urandom);
    v.pterm = 14'($urandom); v.iterm = 12'($urandom); v.fwd = 12'($urandom);
    v.a2d_res = 12'($urandom); v.error = 12'($urandom); v.intgrl = 12'($urandom);
    v.s0 = 3'($urandom_range(0, 7)); v.s1 = 3'($urandom_range(0, 7));
    v.mul = 1'($urandom); v.sub = 1'($urandom); v.m2 = 1'($urandom);
    v.m4 = 1'($urandom); v.sat = 1'($urandom);
    v.exp = model(v);
    return v;
  endfunction

  initial begin
    vec_t v, w;
    v = '0; v.accum = 16'h0080; v.pcomp = 16'h0070; v.s0 = 3; v.sat = 1; v.exp = 16'h00F0; tbl.push_back(v);
    v = '0; v.fwd = 12'h008; v.pterm = 14'h3FFF; v.s1 = 4; v.s0 = 4; v.sub = 1; v.m2 = 1; v.exp = 16'h800A; tbl.push_back(v);
    v = '0; v.accum = 16'h0700; v.intgrl = 12'h200; v.s0 = 1; v.sat = 1; v.exp = 16'h07FF; tbl.push_back(v);
    v = '0; v.error = 12'h800; v.s1 = 2; v.sub = 1; v.a2d_res = 12'h010; v.sat = 1; v.exp = 16'hF800; tbl.push_back(v);
    v = '0; v.error = 12'h800; v.s1 = 3; v.s0 = 5; v.exp = 16'hFF80; tbl.push_back(v);
    v = '0; v.accum = 16'h0100; v.pterm = 14'h0010; v.s0 = 4; v.m2 = 1; v.m4 = 1; v.exp = 16'h0140; tbl.push_back(v);
    v = '0; v.accum = 16'h1000; v.pcomp = 16'h0070; v.s0 = 3; v.mul = 1; v.exp = 16'h0070; tbl.push_back(v);
    v = '0; v.accum = 16'h3FFF; v.pcomp = 16'h3FFF; v.s0 = 3; v.mul = 1; v.exp = 16'h3FFF; tbl.push_back(v);
    v = '0; v.accum = 16'h4001; v.pcomp = 16'h3FFF; v.s0 = 3; v.mul = 1; v.exp = 16'hC000; tbl.push_back(v);
    v = '0; v.accum = 16'h7000; v.pcomp = 16'h0070; v.s0 = 3; v.mul = 1; v.sub = 1; v.m4 = 1; v.sat = 1; v.exp = 16'hFF90; tbl.push_back(v);
    v = '0; v.accum = 16'h0005; v.icomp = 12'hFFF; v.s0 = 2; v.sub = 1; v.exp = 16'h0006; tbl.push_back(v);
    v = '0; v.iterm = 12'hFFF; v.a2d_res = 12'h001; v.s1 = 1; v.exp = 16'h1000; tbl.push_back(v);
    v = '0; v.error = 12'hF00; v.s1 = 2; v.s0 = 5; v.sat = 1; v.exp = 16'hFF00; tbl.push_back(v);
    v = '0; v.accum = 16'h1234; v.pcomp = 16'h5678; v.fwd = 12'hABC; v.s1 = 7; v.s0 = 6; v.exp = 16'h0000; tbl.push_back(v);
    v = '0; v.accum = 16'h0010; v.a2d_res = 12'h001; v.s1 = 0; v.s0 = 7; v.mul = 1; v.exp = 16'h0000; tbl.push_back(v);

    v = rnd(); v.s1 = 0; v.accum = 16'h1111; drive(v);
    @(posedge clk); #1;
    chk("reset", dst, 16'h0000);
    rst = 0;

    foreach (tbl[i]) begin
      chk($sformatf("model_tbl%0d", i), model(tbl[i]), tbl[i].exp);
      apply($sformatf("tbl%0d", i), tbl[i]);
    end

    v = tbl[0]; w = tbl[1];
    apply("lat_first", v);
    drive(w); #2;
    chk("lat_hold", dst, v.exp);
    @(posedge clk); #1;
    chk("lat_next", dst, w.exp);

    v = tbl[2]; drive(v); rst = 1;
    @(posedge clk); #1;
    chk("midreset", dst, 16'h0000);
    rst = 0;
    apply("after_reset", v);

    for (int i = 0; i < 400; i++) apply($sformatf("rand%0d", i), rnd());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
